// File: rtl/divider_client.sv
// Valid/ready front end for a fixed-latency pipelined divider: tracks each operation
// through the divider with a valid/tag shift register and buffers results in a FIFO.
module divider_client #(
   parameter int DATA_WIDTH = 33,
   parameter int LATENCY    = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_numer,
   input  logic [DATA_WIDTH-1:0] in_denom,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic [DATA_WIDTH-1:0] div_numer,
   output logic [DATA_WIDTH-1:0] div_denom,
   input  logic [DATA_WIDTH-1:0] div_quotient,
   input  logic [DATA_WIDTH-1:0] div_remain,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_quotient,
   output logic [DATA_WIDTH-1:0] out_remain,
   output logic [TAG_WIDTH-1:0]  out_tag
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

   logic [LATENCY-1:0]                vld;
   logic [LATENCY-1:0][TAG_WIDTH-1:0] tag;
   logic [CW-1:0]                     outstanding;
   logic [CW-1:0]                     count;
   logic [PW-1:0]                     rd_ptr;
   logic [PW-1:0]                     wr_ptr;
   logic [DATA_WIDTH-1:0]             q_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]             r_mem [FIFO_DEPTH];
   logic [TAG_WIDTH-1:0]              t_mem [FIFO_DEPTH];
   logic                              accept;
   logic                              pop;
   logic                              wr;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // The divider samples every edge; only accepted cycles are tracked.
   assign div_numer    = in_numer;
   assign div_denom    = in_denom;

   assign in_ready     = !reset && (outstanding < DEPTH);
   assign accept       = in_valid && in_ready;
   assign out_valid    = (count != '0);
   assign pop          = out_valid && out_ready;
   assign wr           = vld[0];
   assign out_quotient = q_mem[rd_ptr];
   assign out_remain   = r_mem[rd_ptr];
   assign out_tag      = t_mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld <= '0;
         tag <= '0;
      end else begin
         for (int i = 0; i < LATENCY - 1; i++) begin
            vld[i] <= vld[i+1];
            tag[i] <= tag[i+1];
         end
         vld[LATENCY-1] <= accept;
         tag[LATENCY-1] <= in_tag;
      end
   end

   // Credits are taken at accept, so every in-flight result already owns a FIFO slot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else if (accept && !pop) begin
         outstanding <= outstanding + 1'b1;
      end else if (!accept && pop) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_mem[i] <= '0;
            r_mem[i] <= '0;
            t_mem[i] <= '0;
         end
      end else begin
         if (wr) begin
            q_mem[wr_ptr] <= div_quotient;
            r_mem[wr_ptr] <= div_remain;
            t_mem[wr_ptr] <= tag[0];
            wr_ptr        <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         if (wr && !pop)      count <= count + 1'b1;
         else if (!wr && pop) count <= count - 1'b1;
      end
   end
endmodule
